instr_enc: RTL and testbench
============================

INSTR_ENC -- requirements
Module: instr_enc

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 resetn  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  encode command present.
REQ-004 in_ready  output  1  command accepted when in_valid && in_ready.
REQ-005 in_fmt  input  2  0=R-type, 1=I-type, 2=J-type, 3=LI pseudo-op.
REQ-006 in_code  input  6  funct for R-type; opcode for I/J; ignored for LI.
REQ-007 in_rs, in_rt, in_rd, in_shamt  input  5 each  register/shift fields.
REQ-008 in_imm  input  32  immediate or target (low 16 for I, low 26 for J, full 32 for LI).
REQ-009 out_valid  output  1  out_instr holds a valid word.
REQ-010 out_ready  input  1  word consumed when out_valid && out_ready.
REQ-011 out_instr  output  32  encoded MIPS32 instruction word, FIFO head.
REQ-012 err  output  1  one-cycle pulse on an accepted illegal command.
REQ-013 count  output  16  number of words consumed at the output.
REQ-014 level  output  3  current FIFO occupancy, 0..4.

Function
REQ-015 Encoding: R = {6'b0, rs, rt, rd, shamt, code}; I = {code, rs, rt, imm[15:0]}; J = {code, imm[25:0]}.
REQ-016 Output path: 4-entry FIFO; out_instr/out_valid driven from registered head; an accepted R/I/J command is visible at out_valid no earlier than the next cycle.
REQ-017 FSM states: IDLE, LI_LO.
REQ-018 in_ready = (state==IDLE) && (level<4); space freed by a same-cycle pop is not used (no pass-through).
REQ-019 IDLE, accept R/I/J: push one word, remain IDLE.
REQ-020 IDLE, accept LI with imm[31:16]==0: push ORI rt,$0,imm[15:0] (opcode 6'h0D, rs=0), remain IDLE.
REQ-021 IDLE, accept LI with imm[31:16]!=0: push LUI rt,imm[31:16] (opcode 6'h0F, rs=0); latch rt and imm[15:0]; go LI_LO.
REQ-022 LI_LO: when level<4, push ORI rt,rt,imm_lo and return IDLE; otherwise hold in LI_LO.
REQ-023 Simultaneous push and pop: level unchanged, order preserved.
REQ-024 Pop when empty and push when full never occur (guarded by out_valid/in_ready).
REQ-025 count increments by 1 per output handshake; wraps 16'hFFFF -> 0.
REQ-026 Illegal command (see REQ-031): accepted (in_ready honoured), nothing pushed, err high exactly the following cycle.

Reset
REQ-027 resetn low asynchronously clears FIFO, level=0, out_valid=0, out_instr=0, count=0, err=0, state=IDLE.
REQ-028 Reset during LI_LO discards the pending ORI; only the LUI is lost if not yet consumed.
REQ-029 in_ready is 0 while resetn is low and 1 in the first cycle after release.

Configuration
REQ-030 Macro INSTENC_PSEUDO_EN defined: LI handled per REQ-020..022.
REQ-031 Macro undefined: LI_LO state absent; in_fmt==3 treated as illegal per REQ-026.

Verification
REQ-032 R: code=6'h21, rs=1, rt=2, rd=3, shamt=0 -> out_instr 32'h00221821, err=0.
REQ-033 LI rt=8, imm=32'hDEADBEEF (macro on) -> 32'h3C08DEAD then 32'h3508BEEF, in_ready low for one cycle; macro off -> no word, err pulse.
REQ-034 LI rt=4, imm=32'h00001234 -> single word 32'h34041234; J code=2, imm=26'h0100000 -> 32'h08100000.
REQ-035 out_ready=0, five R commands -> four accepted, level=4, in_ready=0; raise out_ready -> all drained in order, count=4, fifth accepted.
REQ-036 FIFO holds 3 entries with LI (DEAD/BEEF) accepted -> LUI pushed, stall in LI_LO until a pop, then ORI pushed; resetn pulse mid-LI_LO -> level=0, state IDLE, count=0.

Source files
------------

// File: rtl/instr_enc.sv
`default_nettype none
// ============================================================================
// Module   : instr_enc
// Brief    : Encodes R/I/J commands (and the optional LI pseudo-op, enabled by
//            the INSTENC_PSEUDO_EN macro) into MIPS32 words. The words are
//            queued in a 4-entry FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module instr_enc (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_fmt,
    input  logic [5:0]  in_code,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        err,
    output logic [15:0] count,
    output logic [2:0]  level
);

    localparam int         DEPTH  = 4;
    localparam logic [5:0] OP_ORI = 6'h0D;
    localparam logic [5:0] OP_LUI = 6'h0F;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] mem_d [DEPTH];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  level_q, level_d;
    logic [15:0] count_q, count_d;
    logic        err_q, err_d;
    logic        accept, pop, push, idle;
    logic [31:0] push_word;

`ifdef INSTENC_PSEUDO_EN
    typedef enum logic [0:0] {IDLE = 1'b0, LI_LO = 1'b1} state_t;
    state_t      state_q, state_d;
    logic [4:0]  li_rt_q, li_rt_d;
    logic [15:0] li_lo_q, li_lo_d;
    assign idle = (state_q == IDLE);
`else
    logic unused_imm;
    assign idle       = 1'b1;
    assign unused_imm = ^in_imm[31:26];
`endif

    // Ready is gated by resetn so it reads low for the whole reset window.
    assign in_ready  = resetn && idle && (level_q < 3'd4);
    assign accept    = in_valid && in_ready;
    assign out_valid = (level_q != 3'd0);
    assign pop       = out_valid && out_ready;
    assign out_instr = mem_q[rd_ptr_q];
    assign err       = err_q;
    assign count     = count_q;
    assign level     = level_q;

    always_comb begin
        push      = 1'b0;
        push_word = '0;
        err_d     = 1'b0;
`ifdef INSTENC_PSEUDO_EN
        state_d   = state_q;
        li_rt_d   = li_rt_q;
        li_lo_d   = li_lo_q;
        if (state_q == LI_LO) begin
            if (level_q < 3'd4) begin
                push      = 1'b1;
                push_word = {OP_ORI, li_rt_q, li_rt_q, li_lo_q};
                state_d   = IDLE;
            end
        end else
`endif
        if (accept) begin
            case (in_fmt)
                2'd0: begin
                    push      = 1'b1;
                    push_word = {6'b0, in_rs, in_rt, in_rd, in_shamt, in_code};
                end
                2'd1: begin
                    push      = 1'b1;
                    push_word = {in_code, in_rs, in_rt, in_imm[15:0]};
                end
                2'd2: begin
                    push      = 1'b1;
                    push_word = {in_code, in_imm[25:0]};
                end
                default: begin
`ifdef INSTENC_PSEUDO_EN
                    push = 1'b1;
                    if (in_imm[31:16] == 16'h0000) begin
                        push_word = {OP_ORI, 5'd0, in_rt, in_imm[15:0]};
                    end else begin
                        push_word = {OP_LUI, 5'd0, in_rt, in_imm[31:16]};
                        li_rt_d   = in_rt;
                        li_lo_d   = in_imm[15:0];
                        state_d   = LI_LO;
                    end
`else
                    err_d = 1'b1;
`endif
                end
            endcase
        end

        wr_ptr_d = wr_ptr_q + {1'b0, push};
        rd_ptr_d = rd_ptr_q + {1'b0, pop};
        count_d  = count_q + {15'b0, pop};
        case ({push, pop})
            2'b10:   level_d = level_q + 3'd1;
            2'b01:   level_d = level_q - 3'd1;
            default: level_d = level_q;
        endcase
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push) begin
            mem_d[wr_ptr_q] = push_word;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
`ifdef INSTENC_PSEUDO_EN
            state_q  <= IDLE;
            li_rt_q  <= '0;
            li_lo_q  <= '0;
`endif
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            count_q  <= count_d;
            err_q    <= err_d;
`ifdef INSTENC_PSEUDO_EN
            state_q  <= state_d;
            li_rt_q  <= li_rt_d;
            li_lo_q  <= li_lo_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_enc.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_enc
// Brief    : Directed self-checking bench for instr_enc. LI expectations
//            follow INSTENC_PSEUDO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_enc;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_fmt = '0;
    logic [5:0]  in_code = '0;
    logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        err;
    logic [15:0] count;
    logic [2:0]  level;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    instr_enc dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_code(in_code), .in_rs(in_rs), .in_rt(in_rt),
        .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .err(err), .count(count), .level(level)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] f, input logic [5:0] c, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                         input logic [31:0] imm);
        in_fmt = f; in_code = c; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_imm = imm; in_valid = 1'b1;
    endtask

    task automatic send(input logic [1:0] f, input logic [5:0] c, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                        input logic [31:0] imm, output bit ok);
        int n = 0;
        ok = 1'b0;
        drive(f, c, rs, rt, rd, sh, imm);
        while (!ok && n < 20) begin
            if (in_ready) ok = 1'b1;
            cyc();
            n++;
        end
        in_valid = 1'b0;
    endtask

    task automatic get_word(output logic [31:0] w, output bit ok);
        int n = 0;
        ok = 1'b0;
        w = '0;
        out_ready = 1'b1;
        while (!ok && n < 20) begin
            if (out_valid) begin
                w = out_instr;
                ok = 1'b1;
            end
            cyc();
            n++;
        end
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        #3 resetn = 1'b0;
        #2;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        vectors++; if (out_instr !== 32'h0) begin miscompares++; $display("FAIL rst_out_instr got %h want 0", out_instr); end
        vectors++; if (level !== 3'd0) begin miscompares++; $display("FAIL rst_level got %0d want 0", level); end
        vectors++; if (count !== 16'd0) begin miscompares++; $display("FAIL rst_count got %0d want 0", count); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b want 0", err); end
        @(posedge clk);
        #1 resetn = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rel_in_ready got %b want 1", in_ready); end
        cyc();
    endtask

    task automatic test_r_type();
        bit ok;
        logic [31:0] w;
        send(2'd0, 6'h21, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL r_accept got timeout want accept"); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL r_err got %b want 0", err); end
        vectors++; if (out_instr !== 32'h00221821) begin miscompares++; $display("FAIL r_head got %h want 00221821", out_instr); end
        get_word(w, ok);
        vectors++; if (!ok || w !== 32'h00221821) begin miscompares++; $display("FAIL r_word got %h want 00221821", w); end
        send(2'd0, 6'h00, 5'd0, 5'd9, 5'd10, 5'd4, 32'h0, ok);
        get_word(w, ok);
        vectors++; if (!ok || w !== 32'h00095100) begin miscompares++; $display("FAIL r_sll got %h want 00095100", w); end
    endtask

    task automatic test_ij();
        bit ok;
        logic [31:0] w;
        send(2'd1, 6'h23, 5'd29, 5'd8, 5'd31, 5'd31, 32'hABCD0010, ok);
        get_word(w, ok);
        vectors++; if (!ok || w !== 32'h8FA80010) begin miscompares++; $display("FAIL i_word got %h want 8fa80010", w); end
        send(2'd2, 6'h02, 5'd7, 5'd7, 5'd7, 5'd7, 32'hFC100000, ok);
        get_word(w, ok);
        vectors++; if (!ok || w !== 32'h08100000) begin miscompares++; $display("FAIL j_word got %h want 08100000", w); end
    endtask

    task automatic test_li();
        bit ok;
        logic [31:0] w;
        send(2'd3, 6'h3F, 5'd5, 5'd8, 5'd0, 5'd0, 32'hDEADBEEF, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL li_accept got timeout want accept"); end
`ifdef INSTENC_PSEUDO_EN
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL li_stall_ready got %b want 0", in_ready); end
        vectors++; if (level !== 3'd1) begin miscompares++; $display("FAIL li_level1 got %0d want 1", level); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL li_err got %b want 0", err); end
        cyc();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL li_ready_back got %b want 1", in_ready); end
        vectors++; if (level !== 3'd2) begin miscompares++; $display("FAIL li_level2 got %0d want 2", level); end
        get_word(w, ok);
        vectors++; if (!ok || w !== 32'h3C08DEAD) begin miscompares++; $display("FAIL li_lui got %h want 3c08dead", w); end
        get_word(w, ok);
        vectors++; if (!ok || w !== 32'h3508BEEF) begin miscompares++; $display("FAIL li_ori got %h want 3508beef", w); end
        send(2'd3, 6'h00, 5'd0, 5'd4, 5'd0, 5'd0, 32'h00001234, ok);
        vectors++; if (level !== 3'd1 || in_ready !== 1'b1) begin miscompares++; $display("FAIL li_short level/ready got %0d/%b want 1/1", level, in_ready); end
        get_word(w, ok);
        vectors++; if (!ok || w !== 32'h34041234) begin miscompares++; $display("FAIL li_short_word got %h want 34041234", w); end
        cyc();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL li_short_extra got %b want 0", out_valid); end
`else
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL li_err_pulse got %b want 1", err); end
        vectors++; if (level !== 3'd0) begin miscompares++; $display("FAIL li_no_push got %0d want 0", level); end
        cyc();
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL li_err_len got %b want 0", err); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL li_out_valid got %b want 0", out_valid); end
`endif
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [31:0] exp_w [5] = '{32'h00220820, 32'h00221020, 32'h00221820, 32'h00222020, 32'h00222820};
        logic [31:0] got [5];
        logic [15:0] cnt_after [5];
        int n = 0;
        int t = 0;
        int idx;
        bit acc, popping;
        do_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            send(2'd0, 6'h20, 5'd1, 5'd2, 5'(k), 5'd0, 32'h0, ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL b2b_accept%0d got timeout want accept", k); end
        end
        vectors++; if (level !== 3'd4) begin miscompares++; $display("FAIL b2b_full_level got %0d want 4", level); end
        drive(2'd0, 6'h20, 5'd1, 5'd2, 5'd5, 5'd0, 32'h0);
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_full_ready got %b want 0", in_ready); end
        cyc();
        vectors++; if (level !== 3'd4) begin miscompares++; $display("FAIL b2b_no_overflow got %0d want 4", level); end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin got[i] = '0; cnt_after[i] = '0; end
        while (n < 5 && t < 40) begin
            acc = in_valid && in_ready;
            popping = out_valid;
            idx = n;
            if (popping) begin
                got[n] = out_instr;
                n++;
            end
            cyc();
            if (popping) cnt_after[idx] = count;
            if (acc) in_valid = 1'b0;
            t++;
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        vectors++; if (n !== 5) begin miscompares++; $display("FAIL b2b_drain_n got %0d want 5", n); end
        for (int i = 0; i < 5; i++) begin
            vectors++; if (got[i] !== exp_w[i]) begin miscompares++; $display("FAIL b2b_word%0d got %h want %h", i, got[i], exp_w[i]); end
        end
        vectors++; if (cnt_after[3] !== 16'd4) begin miscompares++; $display("FAIL b2b_count4 got %0d want 4", cnt_after[3]); end
        vectors++; if (count !== 16'd5 || level !== 3'd0) begin miscompares++; $display("FAIL b2b_end count/level got %0d/%0d want 5/0", count, level); end
    endtask

    task automatic test_li_stall();
`ifdef INSTENC_PSEUDO_EN
        bit ok;
        logic [31:0] w;
        logic [31:0] exp_w [4] = '{32'h00221020, 32'h00221820, 32'h3C08DEAD, 32'h3508BEEF};
        do_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) send(2'd0, 6'h20, 5'd1, 5'd2, 5'(k), 5'd0, 32'h0, ok);
        send(2'd3, 6'h00, 5'd0, 5'd8, 5'd0, 5'd0, 32'hDEADBEEF, ok);
        vectors++; if (!ok || level !== 3'd4) begin miscompares++; $display("FAIL stall_lui level got %0d want 4", level); end
        cyc(); cyc(); cyc();
        vectors++; if (level !== 3'd4 || in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_hold level/ready got %0d/%b want 4/0", level, in_ready); end
        out_ready = 1'b1;
        vectors++; if (out_instr !== 32'h00220820) begin miscompares++; $display("FAIL stall_head got %h want 00220820", out_instr); end
        cyc();
        out_ready = 1'b0;
        vectors++; if (level !== 3'd3 || in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_pop level/ready got %0d/%b want 3/0", level, in_ready); end
        cyc();
        vectors++; if (level !== 3'd4) begin miscompares++; $display("FAIL stall_ori_push got %0d want 4", level); end
        for (int i = 0; i < 4; i++) begin
            get_word(w, ok);
            vectors++; if (!ok || w !== exp_w[i]) begin miscompares++; $display("FAIL stall_word%0d got %h want %h", i, w, exp_w[i]); end
        end
        vectors++; if (count !== 16'd5) begin miscompares++; $display("FAIL stall_count got %0d want 5", count); end
`endif
    endtask

    task automatic test_reset_mid();
        bit ok;
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) send(2'd0, 6'h20, 5'd1, 5'd2, 5'(k), 5'd0, 32'h0, ok);
`ifdef INSTENC_PSEUDO_EN
        send(2'd3, 6'h00, 5'd0, 5'd8, 5'd0, 5'd0, 32'hDEADBEEF, ok);
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_in_lilo got %b want 0", in_ready); end
`endif
        resetn = 1'b0;
        #2;
        vectors++; if (level !== 3'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst level/valid got %0d/%b want 0/0", level, out_valid); end
        vectors++; if (count !== 16'd0) begin miscompares++; $display("FAIL mid_rst_count got %0d want 0", count); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ready got %b want 0", in_ready); end
        resetn = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rel_ready got %b want 1", in_ready); end
        cyc(); cyc();
        vectors++; if (level !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_no_ori level/valid/ready got %0d/%b/%b want 0/0/1", level, out_valid, in_ready); end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_ij();
        test_li();
        test_back_to_back();
        test_li_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
